// File: rtl/lutram_fifo_ctrl.sv
// ============================================================================
// lutram_fifo_ctrl : FWFT FIFO sequencer for a bank of 64x1 distributed RAMs
// Revision 1.0
// ============================================================================
`default_nettype none

module lutram_fifo_ctrl #(
   parameter int WIDTH       = 8,
   parameter int AW          = 6,
   parameter int AFULL_LEVEL = (1 << AW) - 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FLUSH,
   input  logic              I_VALID,
   output logic              I_READY,
   input  logic [WIDTH-1:0]  I_DATA,
   output logic              O_VALID,
   input  logic              O_READY,
   output logic [WIDTH-1:0]  O_DATA,
   output logic              RAM_WE,
   output logic [7:0]        RAM_WADR,
   output logic [WIDTH-1:0]  RAM_I,
   output logic [7:0]        RAM_RADR,
   input  logic [WIDTH-1:0]  RAM_RDATA,
   output logic [AW+1:0]     LEVEL,
   output logic              AFULL
);

   localparam logic [AW:0]   C_PTR_ONE   = (AW+1)'(1);
   localparam logic [AW+1:0] C_AFULL_LVL = (AW+2)'(AFULL_LEVEL);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             o_valid_q, o_valid_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;

   logic             w_ram_empty;
   logic             w_ram_full;
   logic             w_push;
   logic             w_pop;
   logic             w_load;
   logic [AW:0]      w_ram_cnt;

   assign w_ram_empty = (wr_ptr_q == rd_ptr_q);
   assign w_ram_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // RST_N gates I_READY directly so nothing is accepted while reset is held.
   assign I_READY = !w_ram_full && !FLUSH && RST_N;
   assign w_push  = I_VALID && I_READY;
   assign w_pop   = o_valid_q && O_READY;
   assign w_load  = !w_ram_empty && (!o_valid_q || w_pop);

   assign RAM_WE   = w_push;
   assign RAM_WADR = 8'(wr_ptr_q[AW-1:0]);
   assign RAM_I    = I_DATA;
   assign RAM_RADR = 8'(rd_ptr_q[AW-1:0]);

   assign O_VALID   = o_valid_q;
   assign O_DATA    = o_data_q;
   assign w_ram_cnt = wr_ptr_q - rd_ptr_q;
   assign LEVEL     = {1'b0, w_ram_cnt} + {{(AW+1){1'b0}}, o_valid_q};
   assign AFULL     = (LEVEL >= C_AFULL_LVL);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      if (FLUSH) begin
         // Discard everything: RAM emptied by catching the read pointer up.
         rd_ptr_d  = wr_ptr_q;
         o_valid_d = 1'b0;
      end else begin
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
         end
         if (w_load) begin
            o_data_d  = RAM_RDATA;
            o_valid_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + C_PTR_ONE;
         end else if (w_pop) begin
            o_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lutram_fifo_ctrl.sv
// ============================================================================
// tb_lutram_fifo_ctrl : randomized bench with queue-based FIFO reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lutram_fifo_ctrl;

   localparam int WIDTH = 8;
   localparam int AW    = 6;
   localparam int DEPTH = 1 << AW;
   localparam int AFL   = DEPTH - 4;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             FLUSH;
   logic             I_VALID;
   logic             I_READY;
   logic [WIDTH-1:0] I_DATA;
   logic             O_VALID;
   logic             O_READY;
   logic [WIDTH-1:0] O_DATA;
   logic             RAM_WE;
   logic [7:0]       RAM_WADR;
   logic [WIDTH-1:0] RAM_I;
   logic [7:0]       RAM_RADR;
   logic [WIDTH-1:0] RAM_RDATA;
   logic [AW+1:0]    LEVEL;
   logic             AFULL;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [WIDTH-1:0] m_q[$];
   logic             m_ov;
   logic [WIDTH-1:0] m_od;
   int               m_wr;
   int               m_rd;

   // Stand-in for the RAMD64E bank: synchronous write, asynchronous read
   logic [WIDTH-1:0] ram [0:255];

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RAM_WE) ram[RAM_WADR] <= RAM_I;
   end
   assign RAM_RDATA = ram[RAM_RADR];

   lutram_fifo_ctrl #(.WIDTH(WIDTH), .AW(AW), .AFULL_LEVEL(AFL)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .FLUSH     (FLUSH),
      .I_VALID   (I_VALID),
      .I_READY   (I_READY),
      .I_DATA    (I_DATA),
      .O_VALID   (O_VALID),
      .O_READY   (O_READY),
      .O_DATA    (O_DATA),
      .RAM_WE    (RAM_WE),
      .RAM_WADR  (RAM_WADR),
      .RAM_I     (RAM_I),
      .RAM_RADR  (RAM_RADR),
      .RAM_RDATA (RAM_RDATA),
      .LEVEL     (LEVEL),
      .AFULL     (AFULL)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ov = 1'b0;
      m_od = '0;
      m_wr = 0;
      m_rd = 0;
   endtask

   // Compare every visible output against what the model says must be seen now.
   task automatic compare();
      int lvl;
      bit exp_rdy;
      lvl     = m_q.size() + int'(m_ov);
      exp_rdy = RST_N && (m_q.size() < DEPTH) && !FLUSH;
      chk("I_READY",  int'(I_READY),  int'(exp_rdy));
      chk("RAM_WE",   int'(RAM_WE),   int'(exp_rdy && I_VALID));
      chk("RAM_WADR", int'(RAM_WADR), m_wr % DEPTH);
      chk("RAM_I",    int'(RAM_I),    int'(I_DATA));
      chk("RAM_RADR", int'(RAM_RADR), m_rd % DEPTH);
      chk("O_VALID",  int'(O_VALID),  int'(m_ov));
      chk("O_DATA",   int'(O_DATA),   int'(m_od));
      chk("LEVEL",    int'(LEVEL),    lvl);
      chk("AFULL",    int'(AFULL),    int'(lvl >= AFL));
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit push, pop, load;
      push = I_VALID && (m_q.size() < DEPTH) && !FLUSH;
      if (FLUSH) begin
         m_q.delete();
         m_ov = 1'b0;
         m_rd = m_wr;
      end else begin
         pop  = m_ov && O_READY;
         load = (m_q.size() > 0) && (!m_ov || pop);
         if (load) begin
            m_od = m_q.pop_front();
            m_ov = 1'b1;
            m_rd++;
         end else if (pop) begin
            m_ov = 1'b0;
         end
         if (push) begin
            m_q.push_back(I_DATA);
            m_wr++;
         end
      end
   endtask

   task automatic step(input logic iv, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic fl);
      I_VALID = iv;
      I_DATA  = d;
      O_READY = ordy;
      FLUSH   = fl;
      @(negedge CLK);
      compare();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_N   = 1'b0;
      FLUSH   = 1'b0;
      I_VALID = 1'b1;
      I_DATA  = 8'h11;
      O_READY = 1'b0;
      model_reset();
      #1;
      chk("rst_I_READY", int'(I_READY), 0);
      chk("rst_RAM_WE",  int'(RAM_WE),  0);
      chk("rst_O_VALID", int'(O_VALID), 0);
      chk("rst_LEVEL",   int'(LEVEL),   0);
      chk("rst_AFULL",   int'(AFULL),   0);
      @(posedge CLK);
      #1;
      I_VALID = 1'b0;
      RST_N   = 1'b1;
      #1;
      chk("rel_I_READY", int'(I_READY), 1);

      // Single word with consumer stalled: two edges to reach the output.
      step(1'b0, 8'h00, 1'b0, 1'b0);
      I_VALID = 1'b1;
      I_DATA  = 8'hA5;
      #1;
      chk("one_RAM_WE",   int'(RAM_WE),   1);
      chk("one_RAM_WADR", int'(RAM_WADR), 0);
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("one_E0_O_VALID", int'(O_VALID), 0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("one_O_VALID",  int'(O_VALID),  1);
      chk("one_O_DATA",   int'(O_DATA),   8'hA5);
      chk("one_LEVEL",    int'(LEVEL),    1);
      chk("one_RAM_RADR", int'(RAM_RADR), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("one_popped", int'(O_VALID), 0);

      // Fill: 64 in RAM plus the output register.
      for (int i = 0; i < 65; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 58) chk("fill_AFULL_59", int'(AFULL), 0);
         if (i == 59) chk("fill_AFULL_60", int'(AFULL), 1);
      end
      chk("fill_LEVEL", int'(LEVEL), 65);
      chk("fill_O_DATA", int'(O_DATA), 0);
      I_VALID = 1'b1;
      #1;
      chk("fill_I_READY", int'(I_READY), 0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("fill_stall_LEVEL", int'(LEVEL), 65);

      // Pop at full: push stays blocked that edge, accepted on the next.
      step(1'b1, 8'hEE, 1'b1, 1'b0);
      chk("full_pop_LEVEL",  int'(LEVEL),  64);
      chk("full_pop_O_DATA", int'(O_DATA), 1);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("full_refill_LEVEL", int'(LEVEL), 65);
      for (int i = 0; i < 70; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drained_LEVEL", int'(LEVEL), 0);

      // FLUSH at LEVEL 10 with a pending push.
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      chk("pre_flush_LEVEL", int'(LEVEL), 10);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("flush_O_VALID", int'(O_VALID), 0);
      chk("flush_LEVEL",   int'(LEVEL),   0);
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_flush_O_DATA", int'(O_DATA), 8'h3C);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Continuous streaming across several pointer wraps.
      for (int i = 0; i < 200; i++) step(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));
      end

      // Asynchronous reset while the output register is occupied.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
      chk("pre_rst_O_VALID", int'(O_VALID), 1);
      #2;
      I_VALID = 1'b1;
      RST_N   = 1'b0;
      #1;
      model_reset();
      chk("arst_O_VALID", int'(O_VALID), 0);
      chk("arst_I_READY", int'(I_READY), 0);
      chk("arst_RAM_WE",  int'(RAM_WE),  0);
      chk("arst_LEVEL",   int'(LEVEL),   0);
      chk("arst_O_DATA",  int'(O_DATA),  0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
